// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port (I) and the load/store port (D) of the core. Data accesses win
// contention; a starvation counter forces an I grant after STARVE_MAX
// consecutive contested D grants. Every access takes IDLE -> BUSY -> DONE.
// Optional macro MEM_ARB_TIMEOUT_EN: abort a memory access after TIMEOUT
// cycles without m_ready and flag it with err alongside the ack.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("mem_arbiter: STARVE_MAX and TIMEOUT must both be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          d_wins;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    // D wins unless I is also waiting and has been passed over STARVE_MAX times
    always_comb begin
        d_wins = d_req && !(i_req && (starve_cnt == SW'(STARVE_MAX)));
    end

    // Arbitration FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state   <= D_BUSY;
                        m_en    <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        // only contested wins count; d_wins already implies below max
                        if (i_req && (starve_cnt != SW'(STARVE_MAX))) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else if (i_req) begin
                        state      <= I_BUSY;
                        m_en       <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        starve_cnt <= '0;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                I_BUSY, D_BUSY: begin
                    if (m_ready) begin
                        state <= DONE;
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                        if (state == I_BUSY) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        state <= DONE;
                        m_en  <= 1'b0;
                        m_we  <= 1'b0;
                        err   <= 1'b1;
                        if (state == I_BUSY) begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A small memory responder
// inside step() raises m_ready after mem_wait cycles of m_en (or never when
// mem_hang is set). The timeout scenario runs only with MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          err;

    int            checks   = 0;
    int            failures = 0;
    int            mem_wait = 0;
    bit            mem_hang = 1'b0;
    logic [DW-1:0] mem_data = '0;
    int            busy_cnt = 0;
    logic          prev_i_ack = 1'b0;
    logic          prev_d_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .STARVE_MAX(4),
        .TIMEOUT   (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_ack  (i_ack),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_ack  (d_ack),
        .m_en   (m_en),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ready(m_ready),
        .err    (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock: sample #1 after the edge, then update the memory responder
    task automatic step();
        @(posedge clk);
        #1;
        if (m_en) begin
            m_ready = !mem_hang && (busy_cnt == mem_wait);
            busy_cnt++;
        end else begin
            m_ready  = 1'b0;
            busy_cnt = 0;
        end
        m_rdata = mem_data;
        if (i_ack || d_ack) begin
            check("ack_exclusive", 64'(i_ack & d_ack), 64'd0);
            check("ack_one_cycle", 64'((i_ack & prev_i_ack) | (d_ack & prev_d_ack)), 64'd0);
        end
        prev_i_ack = i_ack;
        prev_d_ack = d_ack;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_en && n < 20);
        check(tag, 64'(m_en), 64'd1);
    endtask

    task automatic wait_ack(input string tag, output logic [1:0] which);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(i_ack || d_ack) && n < 40);
        check(tag, 64'(i_ack | d_ack), 64'd1);
        which = {i_ack, d_ack};
    endtask

    logic [1:0]    who;
    bit            exp_d     [6] = '{1, 1, 1, 1, 0, 1};
    int            exp_starve[6] = '{1, 2, 3, 4, 0, 1};
    bit            saw_ack;
    int            en_cycles;

    initial begin
        reset   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ready = 1'b0;
        repeat (3) step();

        // reset state
        check("rst_m_en", 64'(m_en), 64'd0);
        check("rst_m_we", 64'(m_we), 64'd0);
        check("rst_m_addr_wdata", {m_addr, m_wdata}, 64'd0);
        check("rst_acks_err", 64'({i_ack, d_ack, err}), 64'd0);
        check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        reset = 1'b1;
        step();

        // I only, zero wait: req in cycle n, m_en in n+1 only, ack in n+2
        i_req    = 1'b1;
        i_addr   = 32'h100;
        mem_wait = 0;
        mem_data = 32'h2002_0005;
        step();
        check("t2_m_en", 64'(m_en), 64'd1);
        check("t2_m_addr", 64'(m_addr), 64'h100);
        check("t2_m_we", 64'(m_we), 64'd0);
        step();
        check("t2_m_en_one_cycle", 64'(m_en), 64'd0);
        check("t2_i_ack", 64'(i_ack), 64'd1);
        check("t2_i_rdata", 64'(i_rdata), 64'h2002_0005);
        i_req = 1'b0;
        step();
        check("t2_i_ack_drop", 64'(i_ack), 64'd0);

        // simultaneous I fetch and D store, 2 wait states: D first, then I
        i_req    = 1'b1;
        i_addr   = 32'h104;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h40;
        d_wdata  = 32'hABCD;
        mem_wait = 2;
        mem_data = 32'hDEAD_BEEF;
        step();
        check("t3_d_m_en", 64'(m_en), 64'd1);
        check("t3_d_m_we", 64'(m_we), 64'd1);
        check("t3_d_m_addr", 64'(m_addr), 64'h40);
        check("t3_d_m_wdata", 64'(m_wdata), 64'hABCD);
        wait_ack("t3_first_ack_seen", who);
        check("t3_first_ack_is_d", 64'(who), 64'b01);
        check("t3_store_rdata_held", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        wait_grant("t3_i_grant");
        check("t3_i_m_we", 64'(m_we), 64'd0);
        check("t3_i_m_addr", 64'(m_addr), 64'h104);
        wait_ack("t3_second_ack_seen", who);
        check("t3_second_ack_is_i", 64'(who), 64'b10);
        check("t3_i_rdata", 64'(i_rdata), 64'hDEAD_BEEF);
        i_req = 1'b0;

        // both held: grants D,D,D,D,I,D with starve_cnt 1,2,3,4,0,1
        i_req    = 1'b1;
        i_addr   = 32'h200;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h300;
        mem_wait = 0;
        mem_data = 32'h11;
        for (int g = 0; g < 6; g++) begin
            wait_grant($sformatf("t4_grant%0d", g));
            check($sformatf("t4_addr%0d", g), 64'(m_addr), exp_d[g] ? 64'h300 : 64'h200);
            check($sformatf("t4_starve%0d", g), 64'(dut.starve_cnt), 64'(exp_starve[g]));
            wait_ack($sformatf("t4_ack_seen%0d", g), who);
            check($sformatf("t4_ack_owner%0d", g), 64'(who), exp_d[g] ? 64'b01 : 64'b10);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // load with 7 wait states: memory side stable, ack only after m_ready
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_addr   = 32'h80;
        mem_wait = 7;
        mem_data = 32'h1234_5678;
        wait_grant("t5_grant");
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t5_wait%0d_en_addr", k), {31'd0, m_en, m_addr}, {31'd0, 1'b1, 32'h80});
            check($sformatf("t5_wait%0d_no_ack", k), 64'(d_ack), 64'd0);
            step();
        end
        check("t5_ready_cycle_en", 64'(m_en), 64'd1);
        step();
        check("t5_d_ack", 64'(d_ack), 64'd1);
        check("t5_d_rdata", 64'(d_rdata), 64'h1234_5678);
        d_req = 1'b0;
        step();

        // reset for 2 cycles in the middle of a D access
        d_req    = 1'b1;
        d_addr   = 32'h44;
        mem_wait = 20;
        wait_grant("t1_grant");
        step();
        step();
        reset = 1'b0;
        step();
        check("t1_m_en_next_edge", 64'(m_en), 64'd0);
        check("t1_no_ack", 64'({i_ack, d_ack}), 64'd0);
        d_req = 1'b0;
        step();
        check("t1_m_we_addr_wdata", {31'd0, m_we, m_addr}, 64'd0);
        check("t1_m_wdata", 64'(m_wdata), 64'd0);
        check("t1_rdata_cleared", {i_rdata, d_rdata}, 64'd0);
        check("t1_err", 64'(err), 64'd0);
        reset   = 1'b1;
        saw_ack = 1'b0;
        repeat (5) begin
            step();
            if (i_ack || d_ack || m_en) saw_ack = 1'b1;
        end
        check("t1_quiet_after_reset", 64'(saw_ack), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // good load first so the aborted load visibly zeroes d_rdata
        d_req    = 1'b1;
        d_addr   = 32'h90;
        mem_wait = 0;
        mem_data = 32'h55AA;
        wait_ack("t6_pre_ack_seen", who);
        check("t6_pre_rdata", 64'(d_rdata), 64'h55AA);
        check("t6_pre_err", 64'(err), 64'd0);
        mem_hang = 1'b1;
        wait_grant("t6_grant");
        en_cycles = 0;
        while (m_en && en_cycles < 30) begin
            en_cycles++;
            step();
        end
        check("t6_wait_cycles", 64'(en_cycles), 64'd8);
        check("t6_d_ack", 64'(d_ack), 64'd1);
        check("t6_err", 64'(err), 64'd1);
        check("t6_rdata_zero", 64'(d_rdata), 64'd0);
        d_req    = 1'b0;
        mem_hang = 1'b0;
        step();
        check("t6_err_pulse", 64'({err, d_ack}), 64'd0);
        i_req    = 1'b1;
        i_addr   = 32'h100;
        mem_data = 32'h77;
        wait_ack("t6_next_ack_seen", who);
        check("t6_next_is_i", 64'(who), 64'b10);
        check("t6_next_rdata", 64'(i_rdata), 64'h77);
        check("t6_next_err", 64'(err), 64'd0);
        i_req = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
